race_stimulus_gen: RTL and testbench

- Transmitter side of the first-signal detector interface.
- Launches one "race" on three lines a/b/c, with programmable per-channel start delays.
- Holds the lines while the detector latches its result, then samples the detector's 3-bit output and compares it with the expected winner set.
- Sits in the self-test path beside the detector; drives the detector's inputs and its active-low reset.

---
 rtl/race_stimulus_gen.sv | 170 +++++++++++++++++
 tb/tb_race_stimulus_gen.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_stimulus_gen.sv
// race_stimulus_gen: launches one race on lines a/b/c with per-channel start
// delays, holds the lines while the first-signal detector latches, then
// samples the detector result and compares it against the expected winners.
`timescale 1ns/1ps

module race_stimulus_gen #(
  parameter int DW          = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] delay_a,
  input  logic [DW-1:0] delay_b,
  input  logic [DW-1:0] delay_c,
  input  logic [2:0]    chan_en,
  output logic          a,
  output logic          b,
  output logic          c,
  output logic          det_rst_n,
  input  logic [2:0]    y_in,
  output logic          busy,
  output logic          done,
  output logic [2:0]    expected,
  output logic          match
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, HOLD, CHECK} state_t;

  // Hold counter only needs to count 0 .. HOLD_CYCLES-1.
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t        state, state_nx;
  logic [DW-1:0] cnt, cnt_nx, cnt_inc;
  logic [HW-1:0] hold_cnt, hold_cnt_nx;
  logic [DW-1:0] dly_a_q, dly_b_q, dly_c_q;
  logic [DW-1:0] dly_a_nx, dly_b_nx, dly_c_nx;
  logic [2:0]    en_q, en_nx;
  logic [2:0]    lines, lines_nx;
  logic          det_rst_n_nx, busy_nx, done_nx, match_nx;
  logic [2:0]    expected_nx;
  logic [DW-1:0] min_dly;
  logic [2:0]    winners;
  logic [2:0]    fire_arm, fire_run;

  assign {c, b, a} = lines;

  // Winner set for the race being requested: every enabled channel whose
  // delay equals the smallest enabled delay (ties give several bits).
  always_comb begin
    min_dly = '1;
    if (chan_en[0] && (delay_a < min_dly)) min_dly = delay_a;
    if (chan_en[1] && (delay_b < min_dly)) min_dly = delay_b;
    if (chan_en[2] && (delay_c < min_dly)) min_dly = delay_c;
    winners = chan_en & {delay_c == min_dly, delay_b == min_dly, delay_a == min_dly};
  end

  // Saturating counter step, and which channels fire for the counter value
  // that will be visible in the next cycle.
  always_comb begin
    cnt_inc  = (cnt == '1) ? cnt : cnt + DW'(1);
    fire_arm = en_q & {dly_c_q == '0, dly_b_q == '0, dly_a_q == '0};
    fire_run = en_q & {cnt_inc == dly_c_q, cnt_inc == dly_b_q, cnt_inc == dly_a_q};
  end

  // Next-state and next-output logic; every output is registered, so each
  // branch prepares the values that belong to the state being entered.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    hold_cnt_nx  = hold_cnt;
    dly_a_nx     = dly_a_q;
    dly_b_nx     = dly_b_q;
    dly_c_nx     = dly_c_q;
    en_nx        = en_q;
    lines_nx     = lines;
    det_rst_n_nx = det_rst_n;
    busy_nx      = busy;
    done_nx      = 1'b0;
    expected_nx  = expected;
    match_nx     = match;

    case (state)
      IDLE: begin
        lines_nx     = '0;
        det_rst_n_nx = 1'b1;
        busy_nx      = 1'b0;
        if (start) begin
          dly_a_nx     = delay_a;
          dly_b_nx     = delay_b;
          dly_c_nx     = delay_c;
          en_nx        = chan_en;
          expected_nx  = winners;
          match_nx     = 1'b0;
          busy_nx      = 1'b1;
          det_rst_n_nx = 1'b0;
          cnt_nx       = '0;
          state_nx     = ARM;
        end
      end
      ARM: begin
        cnt_nx       = '0;
        lines_nx     = fire_arm;
        det_rst_n_nx = 1'b1;
        state_nx     = RUN;
      end
      RUN: begin
        if ((lines & en_q) == en_q) begin
          hold_cnt_nx = '0;
          state_nx    = HOLD;
        end else begin
          cnt_nx   = cnt_inc;
          lines_nx = lines | fire_run;
        end
      end
      HOLD: begin
        if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
          done_nx  = 1'b1;
          state_nx = CHECK;
        end else begin
          hold_cnt_nx = hold_cnt + HW'(1);
        end
      end
      CHECK: begin
        match_nx = (y_in == expected);
        lines_nx = '0;
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything immediately,
  // including lines that are high mid-race.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_cnt  <= '0;
      dly_a_q   <= '0;
      dly_b_q   <= '0;
      dly_c_q   <= '0;
      en_q      <= '0;
      lines     <= '0;
      det_rst_n <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      expected  <= '0;
      match     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      dly_a_q   <= dly_a_nx;
      dly_b_q   <= dly_b_nx;
      dly_c_q   <= dly_c_nx;
      en_q      <= en_nx;
      lines     <= lines_nx;
      det_rst_n <= det_rst_n_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      expected  <= expected_nx;
      match     <= match_nx;
    end
  end

endmodule

// File: tb/tb_race_stimulus_gen.sv
// Testbench for race_stimulus_gen: a behavioural first-signal detector feeds
// y_in, races are launched from a vector table plus hand-written sequences,
// and a monitor compares each race against a scoreboard entry.
`timescale 1ns/1ps

module tb_race_stimulus_gen;

  localparam int DW = 8;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] delay_a = '0;
  logic [DW-1:0] delay_b = '0;
  logic [DW-1:0] delay_c = '0;
  logic [2:0]    chan_en = '0;
  logic          a, b, c, det_rst_n, busy, done, match;
  logic [2:0]    expected;
  logic [2:0]    y_in;
  logic [2:0]    det_q = '0;
  logic          force_y = 1'b0;
  logic [2:0]    force_val = '0;

  typedef struct {
    logic [7:0] da, db, dc;
    logic [2:0] en;
    logic       fy;
    logic [2:0] fv;
    logic [2:0] exp_expected;
    logic       exp_match;
  } vec_t;

  typedef struct {
    int         fa, fb, fc, done_edge;
    logic [2:0] exp_expected;
    logic       exp_match;
  } sb_t;

  int   check_cnt = 0;
  int   pass_cnt  = 0;
  sb_t  sb[$];
  sb_t  cur;
  vec_t vecs[8];

  int   edge_n, fa_obs, fb_obs, fc_obs, det_low, viol;
  bit   mon_active = 1'b0;
  bit   match_pending = 1'b0;
  bit   busy_d = 1'b0;

  assign y_in = force_y ? force_val : det_q;

  always #5 clk = ~clk;

  race_stimulus_gen #(.DW(DW), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst), .start(start),
    .delay_a(delay_a), .delay_b(delay_b), .delay_c(delay_c),
    .chan_en(chan_en), .a(a), .b(b), .c(c), .det_rst_n(det_rst_n),
    .y_in(y_in), .busy(busy), .done(done), .expected(expected), .match(match)
  );

  // Behavioural detector: captures the first nonzero line pattern after its reset.
  always @(posedge clk) begin
    if (!det_rst_n) det_q <= '0;
    else if (det_q == '0) det_q <= {c, b, a};
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Timing model: line x first high after edge 1+delay_x (edge 0 = acceptance),
  // done after edge 2 + largest enabled delay + H.
  function automatic sb_t makeExp(input vec_t v);
    sb_t r;
    int  dmax = 0;
    r.fa = v.en[0] ? 1 + int'(v.da) : -1;
    r.fb = v.en[1] ? 1 + int'(v.db) : -1;
    r.fc = v.en[2] ? 1 + int'(v.dc) : -1;
    if (v.en[0] && int'(v.da) > dmax) dmax = int'(v.da);
    if (v.en[1] && int'(v.db) > dmax) dmax = int'(v.db);
    if (v.en[2] && int'(v.dc) > dmax) dmax = int'(v.dc);
    r.done_edge    = 2 + dmax + H;
    r.exp_expected = v.exp_expected;
    r.exp_match    = v.exp_match;
    return r;
  endfunction

  // Monitor: pops a scoreboard entry at each launch and checks the race.
  always @(negedge clk) begin
    if (!rst) begin
      mon_active    = 1'b0;
      match_pending = 1'b0;
      busy_d        = 1'b0;
    end else begin
      if (match_pending) begin
        checkOutput("match", match, cur.exp_match);
        checkOutput("done single pulse", done, 0);
        checkOutput("busy after check", busy, 0);
        checkOutput("lines after check", {c, b, a}, 0);
        match_pending = 1'b0;
      end
      if (busy && !busy_d) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected launch", 1, 0);
          mon_active = 1'b0;
        end else begin
          cur        = sb.pop_front();
          mon_active = 1'b1;
          edge_n     = 0;
          fa_obs     = -1;
          fb_obs     = -1;
          fc_obs     = -1;
          det_low    = 0;
          viol       = 0;
          checkOutput("expected at launch", expected, cur.exp_expected);
        end
      end else if (busy) begin
        edge_n++;
      end
      if (mon_active && busy) begin
        if (!det_rst_n) begin
          det_low++;
          if (edge_n != 0) viol++;
          if ({c, b, a} != 3'b000) viol++;
        end
        if (a && fa_obs < 0) fa_obs = edge_n;
        if (b && fb_obs < 0) fb_obs = edge_n;
        if (c && fc_obs < 0) fc_obs = edge_n;
        if (!a && fa_obs >= 0) viol++;
        if (!b && fb_obs >= 0) viol++;
        if (!c && fc_obs >= 0) viol++;
        if (done) begin
          checkOutput("a rise edge", fa_obs, cur.fa);
          checkOutput("b rise edge", fb_obs, cur.fb);
          checkOutput("c rise edge", fc_obs, cur.fc);
          checkOutput("done edge", edge_n, cur.done_edge);
          checkOutput("det_rst_n low cycles", det_low, 1);
          checkOutput("line protocol violations", viol, 0);
          checkOutput("expected held", expected, cur.exp_expected);
          mon_active    = 1'b0;
          match_pending = 1'b1;
        end
      end else if (busy && done) begin
        checkOutput("unexpected done", 1, 0);
      end
      busy_d = busy;
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 600);
    checkOutput("race finished in time", busy, 0);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v, input bit pulse_mid);
    @(negedge clk);
    delay_a   = v.da;
    delay_b   = v.db;
    delay_c   = v.dc;
    chan_en   = v.en;
    force_y   = v.fy;
    force_val = v.fv;
    sb.push_back(makeExp(v));
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    delay_a = 8'($urandom);
    delay_b = 8'($urandom);
    delay_c = 8'($urandom);
    chan_en = 3'($urandom);
    if (pulse_mid) begin
      repeat (4) @(negedge clk);
      start   = 1'b1;
      delay_a = '0;
      delay_b = '0;
      delay_c = '0;
      chan_en = 3'b111;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    force_y = 1'b0;
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t bb, rv, gv;
    int   n, falls, gap;
    bit   prev;

    vecs[0] = '{8'd5,   8'd2, 8'd9, 3'b111, 1'b0, 3'b000, 3'b010, 1'b1};
    vecs[1] = '{8'd3,   8'd3, 8'd7, 3'b111, 1'b0, 3'b000, 3'b011, 1'b1};
    vecs[2] = '{8'd3,   8'd3, 8'd7, 3'b111, 1'b1, 3'b001, 3'b011, 1'b0};
    vecs[3] = '{8'd0,   8'd1, 8'd3, 3'b110, 1'b0, 3'b000, 3'b010, 1'b1};
    // c ties b here, so both are winners
    vecs[4] = '{8'd0,   8'd1, 8'd1, 3'b110, 1'b0, 3'b000, 3'b110, 1'b1};
    vecs[5] = '{8'd7,   8'd7, 8'd7, 3'b000, 1'b0, 3'b000, 3'b000, 1'b1};
    vecs[6] = '{8'd255, 8'd0, 8'd0, 3'b001, 1'b0, 3'b000, 3'b001, 1'b1};
    vecs[7] = '{8'd4,   8'd4, 8'd4, 3'b111, 1'b0, 3'b000, 3'b111, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset lines", {c, b, a}, 0);
    checkOutput("reset det_rst_n", det_rst_n, 0);
    checkOutput("reset busy/done", {busy, done}, 0);
    checkOutput("reset expected/match", {expected, match}, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle det_rst_n", det_rst_n, 1);
    checkOutput("idle busy", busy, 0);

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], 1'b0);

    // Start pulse during RUN must be ignored
    gv = '{8'd6, 8'd8, 8'd10, 3'b111, 1'b0, 3'b000, 3'b001, 1'b1};
    applyStimulus(gv, 1'b1);

    // Start held high: two back-to-back races separated by one IDLE cycle
    bb = '{8'd2, 8'd1, 8'd3, 3'b111, 1'b0, 3'b000, 3'b010, 1'b1};
    @(negedge clk);
    delay_a = bb.da;
    delay_b = bb.db;
    delay_c = bb.dc;
    chan_en = bb.en;
    sb.push_back(makeExp(bb));
    sb.push_back(makeExp(bb));
    start = 1'b1;
    falls = 0;
    gap   = 0;
    n     = 0;
    prev  = 1'b0;
    while (falls < 2 && n < 200) begin
      @(negedge clk);
      n++;
      if (prev && !busy) begin
        falls++;
        if (falls == 2) start = 1'b0;
      end
      if (falls == 1 && !busy) gap++;
      prev = busy;
    end
    start = 1'b0;
    checkOutput("back-to-back races completed", falls, 2);
    checkOutput("relaunch idle gap", gap, 1);
    repeat (2) @(negedge clk);
    checkOutput("no third launch", busy, 0);

    // Asynchronous reset mid-RUN while b is high
    rv = '{8'd20, 8'd2, 8'd30, 3'b111, 1'b0, 3'b000, 3'b010, 1'b1};
    @(negedge clk);
    delay_a = rv.da;
    delay_b = rv.db;
    delay_c = rv.dc;
    chan_en = rv.en;
    sb.push_back(makeExp(rv));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!b && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b high before reset", b, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async reset lines", {c, b, a}, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset expected", expected, 0);
    checkOutput("async reset match", match, 0);
    checkOutput("async reset det_rst_n", det_rst_n, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post-reset det_rst_n", det_rst_n, 1);
    checkOutput("post-reset busy", busy, 0);
    applyStimulus(vecs[0], 1'b0);

    checkOutput("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
